// File: rtl/io_dly_gray_stepper_if.sv
// Request/status bundle for the gray-coded delay-line stepper.
interface io_dly_gray_stepper_if;
  logic [6:0] tgt_code;
  logic       tgt_valid;
  logic       tgt_ready;
  logic       freeze;
  logic [6:0] gray;
  logic [6:0] cur_code;
  logic       busy;
  logic       done;

  modport master (
    output tgt_code, tgt_valid, freeze,
    input  tgt_ready, gray, cur_code, busy, done
  );

  modport slave (
    input  tgt_code, tgt_valid, freeze,
    output tgt_ready, gray, cur_code, busy, done
  );
endinterface

// File: rtl/io_dly_gray_stepper.sv
// Walks a delay-line code one step at a time toward a requested target,
// driving a registered gray code with a settle gap between steps.
module io_dly_gray_stepper #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAX_CODE   = 64,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  io_dly_gray_stepper_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE} state_t;

  localparam logic [6:0] MAX7   = 7'(MAX_CODE);
  localparam logic [6:0] RST7   = 7'(RESET_CODE);
  localparam logic [3:0] CNT_LD = 4'(SETTLE_CYC - 1);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_code, w_code_nxt;
  logic [6:0] r_gray;
  logic [6:0] r_target, w_target_nxt;
  logic [6:0] w_req;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_done, w_done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_code   <= RST7;
      r_gray   <= RST7 ^ (RST7 >> 1);
      r_target <= RST7;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      // gray is derived from the next code so both registers move together
      r_gray   <= w_code_nxt ^ (w_code_nxt >> 1);
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_req        = (bus.tgt_code > MAX7) ? MAX7 : bus.tgt_code;

    unique case (r_state)
      S_IDLE: begin
        // freeze does not gate acceptance; it only holds STEP/SETTLE
        if (bus.tgt_valid) begin
          w_target_nxt = w_req;
          if (w_req == r_code) w_done_nxt  = 1'b1;
          else                 w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        if (!bus.freeze) begin
          w_code_nxt  = (r_target > r_code) ? r_code + 7'd1 : r_code - 7'd1;
          w_cnt_nxt   = CNT_LD;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!bus.freeze) begin
          if (r_cnt == '0) begin
            if (r_code == r_target) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_STEP;
            end
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.tgt_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.cur_code  = r_code;
  assign bus.gray      = r_gray;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_io_dly_gray_stepper.sv
// Randomized and directed bench for io_dly_gray_stepper against a
// move-level timing model (unfrozen cycles elapsed -> steps completed).
module tb_io_dly_gray_stepper;

  localparam int S    = 4;
  localparam int MAXC = 64;
  localparam int RC   = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_dly_gray_stepper_if bus ();

  io_dly_gray_stepper #(
    .SETTLE_CYC (S),
    .MAX_CODE   (MAXC),
    .RESET_CODE (RC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int m_code, m_busy, m_done, m_start, m_tgt, m_k, m_n;
  int n_chk  = 0;
  int n_pass = 0;
  int max_seen = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // A move of N codes spans N*(S+1) unfrozen cycles; one step lands at the
  // end of the first cycle of each (S+1)-cycle slot.
  task automatic model_step(input logic r, input logic v, input int code, input logic f);
    int t, steps;
    if (r) begin
      m_code = RC; m_busy = 0; m_done = 0;
    end else if (m_busy == 0) begin
      m_done = 0;
      if (v) begin
        t = (code > MAXC) ? MAXC : code;
        if (t == m_code) m_done = 1;
        else begin
          m_busy = 1; m_start = m_code; m_tgt = t; m_k = 0;
          m_n = (t > m_code) ? t - m_code : m_code - t;
        end
      end
    end else begin
      m_done = 0;
      if (!f) begin
        m_k++;
        steps = (m_k + S) / (S + 1);
        if (steps > m_n) steps = m_n;
        m_code = (m_tgt > m_start) ? m_start + steps : m_start - steps;
        if (m_k == m_n * (S + 1)) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input int code, input logic f);
    logic [6:0] c7;
    c7 = code[6:0];
    @(negedge clk);
    reset = r; bus.tgt_valid = v; bus.tgt_code = c7; bus.freeze = f;
    @(posedge clk);
    model_step(r, v, int'(c7), f);
    #1;
    check("cur_code",  int'(bus.cur_code), m_code);
    check("gray",      int'(bus.gray), m_code ^ (m_code >> 1));
    check("busy",      int'(bus.busy), m_busy);
    check("done",      int'(bus.done), m_done);
    check("tgt_ready", int'(bus.tgt_ready), (m_busy == 0) ? 1 : 0);
    if (int'(bus.cur_code) > max_seen) max_seen = int'(bus.cur_code);
  endtask

  // Idles until done, starting from an already-elapsed count n0.
  task automatic run_until_done(input string tag, input int n0, input int exp_lat);
    int n;
    n = n0;
    for (int i = 0; i < 2000; i++) begin
      cycle(1'b0, 1'b0, 0, 1'b0);
      n++;
      if (bus.done) break;
    end
    check(tag, n, exp_lat);
  endtask

  initial begin
    int n;
    reset = 1'b1; bus.tgt_valid = 1'b0; bus.tgt_code = '0; bus.freeze = 1'b0;
    m_code = RC; m_busy = 0; m_done = 0; m_start = 0; m_tgt = 0; m_k = 0; m_n = 0;

    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 9, 1'b1);

    // 0 -> 5: five steps, 25 cycles from first STEP cycle to done
    cycle(1'b0, 1'b1, 5, 1'b0);
    run_until_done("lat_up5", 0, 25);
    check("gray_at5", int'(bus.gray), 7);

    // 5 -> 2
    cycle(1'b0, 1'b1, 2, 1'b0);
    run_until_done("lat_dn2", 0, 15);
    check("gray_at2", int'(bus.gray), 3);

    // 100 clamps to 64
    cycle(1'b0, 1'b1, 100, 1'b0);
    run_until_done("lat_clamp", 0, 62 * (S + 1));
    check("gray_at64", int'(bus.gray), 'h60);

    // equal target: done next cycle, no motion
    cycle(1'b0, 1'b1, 64, 1'b0);
    check("eq_done", int'(bus.done), 1);

    // freeze 10 cycles mid-SETTLE: 64 -> 60 completes 10 cycles late
    cycle(1'b0, 1'b1, 60, 1'b0);
    repeat (3)  cycle(1'b0, 1'b0, 0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 0, 1'b1);
    run_until_done("lat_freeze", 13, 4 * (S + 1) + 10);

    // acceptance under freeze, stepping only after release
    cycle(1'b0, 1'b1, 62, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 0, 1'b1);
    run_until_done("lat_acc_frz", 0, 2 * (S + 1));

    // reset mid-move at code 17 while heading to 40
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b0, 1'b1, 40, 1'b0);
    n = 0;
    while (bus.cur_code != 7'd17 && n < 200) begin
      cycle(1'b0, 1'b1, 3, 1'b0);
      n++;
    end
    check("reach17", int'(bus.cur_code), 17);
    cycle(1'b1, 1'b0, 0, 1'b0);
    check("rst_code", int'(bus.cur_code), 0);
    check("rst_ready", int'(bus.tgt_ready), 1);
    cycle(1'b0, 1'b0, 0, 1'b0);
    check("rst_nodone", int'(bus.done), 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int code;
      code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127))
                                         : int'($urandom_range(0, 70));
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 7) == 0),
            code,
            ($urandom_range(0, 9) == 0));
    end

    check("max_code_bound", (max_seen <= MAXC) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_dly_gray_stepper.md
IO_DLY_GRAY_STEPPER -- requirements
Module: io_dly_gray_stepper

Interface
REQ-001 Parameter SETTLE_CYC, default 4: idle cycles between consecutive code steps, legal range 1..15.
REQ-002 Parameter MAX_CODE, default 64: highest code driven; 64 equals the all-blocked delay-line setting.
REQ-003 Parameter RESET_CODE, default 0: code loaded at reset, legal range 0..MAX_CODE.
REQ-004 clk  input  1  block clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tgt_code  input  7  requested binary delay code.
REQ-007 tgt_valid  input  1  request strobe.
REQ-008 tgt_ready  output  1  high when a new request is accepted.
REQ-009 freeze  input  1  pauses stepping and settle counting while high.
REQ-010 gray  output  7  registered gray code driven to the 64-tap NAND decoder.
REQ-011 cur_code  output  7  registered binary code currently driven.
REQ-012 busy  output  1  high while a move is in progress.
REQ-013 done  output  1  one-cycle pulse when a request completes.

Function
REQ-014 The block SHALL encode gray = cur_code ^ (cur_code >> 1) in both cur_code and gray, and SHALL update both on the same clock edge, with no combinational path from any input to gray.
REQ-015 The block SHALL implement a three-state FSM: IDLE, STEP and SETTLE.
REQ-016 tgt_ready SHALL equal (state==IDLE) and SHALL be independent of tgt_valid and freeze.
REQ-017 A request SHALL be accepted on the edge where tgt_valid && tgt_ready; the block SHALL latch target = min(tgt_code, MAX_CODE).
REQ-018 If the accepted target equals cur_code, the block SHALL stay in IDLE, leave cur_code unchanged and pulse done on the next cycle.
REQ-019 Otherwise the FSM SHALL go IDLE->STEP, and busy SHALL be high from the following cycle.
REQ-020 STEP SHALL last one cycle; on its exit edge the block SHALL move cur_code by exactly 1 toward target, so that gray changes by exactly one bit per step.
REQ-021 STEP SHALL always go to SETTLE.
REQ-022 On entry to SETTLE the settle counter SHALL load SETTLE_CYC-1.
REQ-023 While in SETTLE the counter SHALL decrement each cycle.
REQ-024 When the counter reaches 0, the FSM SHALL go to STEP if cur_code != target, or to IDLE with a done pulse if cur_code == target.
REQ-025 Step cadence SHALL therefore be one code change every SETTLE_CYC+1 cycles.
REQ-026 A move of N codes SHALL take N*(SETTLE_CYC+1) cycles from the first STEP cycle to done.
REQ-027 While freeze is high, the block SHALL hold state, the settle counter and cur_code.
REQ-028 freeze SHALL NOT block acceptance in IDLE, but an accepted move SHALL NOT start stepping until freeze is low.
REQ-029 tgt_valid while busy SHALL be ignored, because tgt_ready is low; the in-flight target SHALL be kept.
REQ-030 cur_code SHALL never exceed MAX_CODE and SHALL never wrap below 0 or above 127.
REQ-031 done and busy SHALL never be high in the same cycle.
REQ-032 busy SHALL equal (state != IDLE).

Reset
REQ-033 On reset high at a clock edge, the block SHALL set state=IDLE, cur_code=RESET_CODE, gray=RESET_CODE^(RESET_CODE>>1), target=RESET_CODE, settle counter=0, busy=0, done=0 and tgt_ready=1.
REQ-034 Reset asserted mid-move SHALL abort the move with no done pulse.
REQ-035 Reset SHALL take priority over freeze and tgt_valid.

Verification
REQ-036 Reset with default parameters, then target 5 -> gray sequence 0,1,3,2,6,7, one change every 5 cycles, and done pulses 25 cycles after the first STEP cycle.
REQ-037 From code 5, target 2 -> cur_code 4,3,2 and gray 6,2,3; done pulses once, and busy is low on the done cycle.
REQ-038 Target 100 -> clamped to 64; final gray = 0x60; cur_code never exceeds 64.
REQ-039 Target equal to cur_code -> no change on gray, done pulses on the next cycle, and busy stays 0.
REQ-040 freeze held 10 cycles mid-SETTLE -> cur_code and the counter are held; the move completes exactly 10 cycles late.
REQ-041 Reset asserted at code 17 during a move to 40 -> next cycle shows cur_code=0, gray=0, busy=0, no done pulse and tgt_ready=1.
